imem_responder: RTL and testbench

// - Instruction-memory responder: the memory end of the fetch interface driven by the If stage.
// - Accepts fetch requests (valid/ready), returns one 32-bit instruction per request, in order, after LATENCY cycles.
// - Buffers responses when the If stage stalls; flush drops all in-flight fetches on redirect.
// - Backdoor load port writes program words before or between runs.

---
 rtl/imem_responder_pkg.sv | 19 +
 rtl/imem_responder_if.sv | 28 ++
 rtl/imem_responder_resp_fifo.sv | 83 ++++++++
 rtl/imem_responder.sv | 121 ++++++++++++
 tb/tb_imem_responder.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/imem_responder_pkg.sv
// Shared types and address checks for the instruction-memory responder.
package imem_responder_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
    } fetch_resp_t;

    function automatic logic word_in_range(input logic [31:0] addr, input int unsigned depth_words);
        return ({2'b00, addr[31:2]} < depth_words);
    endfunction

    function automatic logic fetch_fault(input logic [31:0] addr, input int unsigned depth_words);
        return (addr[1:0] != 2'b00) || !word_in_range(addr, depth_words);
    endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch, flush and backdoor-load bundle between the If stage and the instruction memory.
interface imem_responder_if;

    logic        io_req_valid;
    logic        io_req_ready;
    logic [31:0] io_req_addr;
    logic        io_resp_valid;
    logic        io_resp_ready;
    logic [31:0] io_resp_inst;
    logic        io_resp_err;
    logic        io_flush;
    logic        io_load_en;
    logic [31:0] io_load_addr;
    logic [31:0] io_load_data;

    modport master (
        output io_req_valid, io_req_addr, io_resp_ready, io_flush,
               io_load_en, io_load_addr, io_load_data,
        input  io_req_ready, io_resp_valid, io_resp_inst, io_resp_err
    );

    modport slave (
        input  io_req_valid, io_req_addr, io_resp_ready, io_flush,
               io_load_en, io_load_addr, io_load_data,
        output io_req_ready, io_resp_valid, io_resp_inst, io_resp_err
    );

endinterface

// File: rtl/imem_responder_resp_fifo.sv
// First-word-fall-through response FIFO; clear empties it and overrides push/pop.
module imem_responder_resp_fifo
    import imem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        push_i,
    input  fetch_resp_t push_data_i,
    input  logic        pop_i,
    input  logic        clear_i,
    output logic        valid_o,
    output fetch_resp_t data_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fetch_resp_t   slot_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push_s, do_pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        if (ptr == LAST_PTR) begin
            return PW'(0);
        end else begin
            return ptr + PW'(1);
        end
    endfunction

    assign do_push_s = push_i && (count_q != FULL_CNT) && !clear_i;
    assign do_pop_s  = pop_i && (count_q != CW'(0)) && !clear_i;

    // Next pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = PW'(0);
            rd_ptr_d = PW'(0);
            count_d  = CW'(0);
        end else begin
            if (do_push_s) wr_ptr_d = ptr_inc(wr_ptr_q);
            else           wr_ptr_d = wr_ptr_q;
            if (do_pop_s)  rd_ptr_d = ptr_inc(rd_ptr_q);
            else           rd_ptr_d = rd_ptr_q;
            if (do_push_s && !do_pop_s)      count_d = count_q + CW'(1);
            else if (!do_push_s && do_pop_s) count_d = count_q - CW'(1);
            else                             count_d = count_q;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= PW'(0);
            rd_ptr_q <= PW'(0);
            count_q  <= CW'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is reset so the head reads as zero while empty after reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) slot_q[i] <= '0;
        end else if (do_push_s) begin
            slot_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign valid_o = (count_q != CW'(0));
    assign data_o  = slot_q[rd_ptr_q];

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: word array, fixed-latency delay line, credit-limited
// acceptance and an in-order response FIFO.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned OUTSTANDING = 2
) (
    input  logic         clock,
    input  logic         reset,
    imem_responder_if.slave bus
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW = $clog2(OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CREDITS = CW'(OUTSTANDING);

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [CW-1:0] credits_q, credits_d;
    logic          req_ready_s, accept_s, consume_s;
    logic          push_valid_s, fifo_valid_s;
    fetch_resp_t   rd_resp_s, push_resp_s, fifo_resp_s;
    logic [AW-1:0] req_idx_s, load_idx_s;

    assign req_idx_s  = bus.io_req_addr[AW+1:2];
    assign load_idx_s = bus.io_load_addr[AW+1:2];

    // Credits count in-flight plus buffered entries, so ready never looks at resp_ready
    assign req_ready_s = !reset && !bus.io_flush && !bus.io_load_en && (credits_q < MAX_CREDITS);
    assign accept_s    = bus.io_req_valid && req_ready_s;
    assign consume_s   = fifo_valid_s && bus.io_resp_ready;

    // Backdoor write; the array itself is never reset
    always_ff @(posedge clock) begin
        if (bus.io_load_en && word_in_range(bus.io_load_addr, DEPTH_WORDS)) begin
            mem_q[load_idx_s] <= bus.io_load_data;
        end
    end

    // Value captured at the accept edge; faults substitute a NOP instead of reading
    always_comb begin
        rd_resp_s = '0;
        if (fetch_fault(bus.io_req_addr, DEPTH_WORDS)) begin
            rd_resp_s.inst = NOP_INST;
            rd_resp_s.err  = 1'b1;
        end else begin
            rd_resp_s.inst = mem_q[req_idx_s];
            rd_resp_s.err  = 1'b0;
        end
    end

    generate
        if (LATENCY == 1) begin : g_direct
            assign push_valid_s = accept_s;
            assign push_resp_s  = rd_resp_s;
        end else begin : g_pipe
            logic [LATENCY-2:0] vld_q;
            fetch_resp_t        dat_q [LATENCY-1];

            // Delay line; flush kills every in-flight fetch
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    vld_q <= '0;
                    for (int i = 0; i < int'(LATENCY) - 1; i++) dat_q[i] <= '0;
                end else begin
                    if (bus.io_flush) begin
                        vld_q <= '0;
                    end else begin
                        vld_q[0] <= accept_s;
                        for (int i = 1; i < int'(LATENCY) - 1; i++) vld_q[i] <= vld_q[i-1];
                    end
                    if (accept_s) dat_q[0] <= rd_resp_s;
                    for (int i = 1; i < int'(LATENCY) - 1; i++) dat_q[i] <= dat_q[i-1];
                end
            end

            assign push_valid_s = vld_q[LATENCY-2];
            assign push_resp_s  = dat_q[LATENCY-2];
        end
    endgenerate

    imem_responder_resp_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_resp_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (push_valid_s),
        .push_data_i (push_resp_s),
        .pop_i       (bus.io_resp_ready),
        .clear_i     (bus.io_flush),
        .valid_o     (fifo_valid_s),
        .data_o      (fifo_resp_s)
    );

    // Credit update; a flush zeroes it regardless of accept or consume
    always_comb begin
        credits_d = credits_q;
        if (bus.io_flush) begin
            credits_d = CW'(0);
        end else if (accept_s && !consume_s) begin
            credits_d = credits_q + CW'(1);
        end else if (!accept_s && consume_s) begin
            credits_d = credits_q - CW'(1);
        end else begin
            credits_d = credits_q;
        end
    end

    // Credit register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) credits_q <= CW'(0);
        else       credits_q <= credits_d;
    end

    assign bus.io_req_ready  = req_ready_s;
    assign bus.io_resp_valid = fifo_valid_s;
    assign bus.io_resp_inst  = fifo_resp_s.inst;
    assign bus.io_resp_err   = fifo_resp_s.err;

endmodule

// File: tb/tb_imem_responder.sv
// Randomised scoreboard bench for imem_responder against a word-array/queue reference model.
module tb_imem_responder;

    localparam int L   = 2;
    localparam int OUT = 2;
    localparam int DW  = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;

    imem_responder_if bus_if ();

    imem_responder #(
        .DEPTH_WORDS (DW),
        .LATENCY     (L),
        .OUTSTANDING (OUT)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [31:0] inst;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [DW];
    int          outstanding = 0;
    int          n_checks = 0;
    int          n_errs = 0;
    bit          dut_acc = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errs++;
            $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    function automatic exp_t predict(input logic [31:0] a, input int due);
        exp_t e;
        e.due = due;
        if ((a % 4 != 0) || (a >= 32'(DW * 4))) begin
            e.inst = 32'h0000_0013;
            e.err  = 1'b1;
        end else begin
            e.inst = ref_mem[a / 4];
            e.err  = 1'b0;
        end
        return e;
    endfunction

    // Monitor and scoreboard, sampled on the falling edge
    always @(negedge clk) begin : mon
        logic pred_ready;
        logic exp_valid;
        if (rst) begin
            chk("reset_resp_valid", 32'(bus_if.io_resp_valid), 32'd0);
            chk("reset_req_ready", 32'(bus_if.io_req_ready), 32'd0);
            chk("reset_resp_inst", bus_if.io_resp_inst, 32'd0);
            chk("reset_resp_err", 32'(bus_if.io_resp_err), 32'd0);
            exp_q.delete();
            outstanding = 0;
            dut_acc = 1'b0;
        end else begin
            pred_ready = !bus_if.io_flush && !bus_if.io_load_en && (outstanding < OUT);
            chk("req_ready", 32'(bus_if.io_req_ready), 32'(pred_ready));
            exp_valid = (exp_q.size() > 0) && (cyc >= exp_q[0].due);
            chk("resp_valid", 32'(bus_if.io_resp_valid), 32'(exp_valid));
            if (exp_valid && bus_if.io_resp_valid) begin
                chk("resp_inst", bus_if.io_resp_inst, exp_q[0].inst);
                chk("resp_err", 32'(bus_if.io_resp_err), 32'(exp_q[0].err));
            end
            dut_acc = bus_if.io_req_valid && bus_if.io_req_ready;
            if (bus_if.io_flush) begin
                exp_q.delete();
                outstanding = 0;
            end else begin
                if (exp_valid && bus_if.io_resp_ready) begin
                    void'(exp_q.pop_front());
                    outstanding--;
                end
                if (pred_ready && bus_if.io_req_valid) begin
                    exp_q.push_back(predict(bus_if.io_req_addr, cyc + L));
                    outstanding++;
                end
            end
            if (bus_if.io_load_en && (bus_if.io_load_addr < 32'(DW * 4))) begin
                ref_mem[bus_if.io_load_addr / 4] = bus_if.io_load_data;
            end
        end
    end

    task automatic step(input logic v, input logic [31:0] a, input logic rr, input logic fl,
                        input logic le, input logic [31:0] la, input logic [31:0] ld);
        @(posedge clk);
        #1;
        bus_if.io_req_valid  = v;
        bus_if.io_req_addr   = a;
        bus_if.io_resp_ready = rr;
        bus_if.io_flush      = fl;
        bus_if.io_load_en    = le;
        bus_if.io_load_addr  = la;
        bus_if.io_load_data  = ld;
    endtask

    task automatic idle(input int n, input logic rr);
        repeat (n) step(1'b0, 32'd0, rr, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned sel;
        sel = $urandom_range(0, 19);
        if (sel < 14)       return 32'($urandom_range(0, 63)) * 32'd4;
        else if (sel < 16)  return 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(1, 3));
        else if (sel < 18)  return 32'd4096 + 32'($urandom_range(0, 4095)) * 32'd4;
        else if (sel == 18) return 32'd4092;
        else                return 32'($urandom());
    endfunction

    initial begin
        logic        rv;
        logic [31:0] ra;
        logic        le;
        logic [31:0] la;
        bus_if.io_req_valid  = 1'b0;
        bus_if.io_req_addr   = 32'd0;
        bus_if.io_resp_ready = 1'b0;
        bus_if.io_flush      = 1'b0;
        bus_if.io_load_en    = 1'b0;
        bus_if.io_load_addr  = 32'd0;
        bus_if.io_load_data  = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Preload every word through the backdoor
        for (int i = 0; i < DW; i++) begin
            step(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 32'(i) * 32'd4,
                 (i == 0) ? 32'h0050_0093 : 32'($urandom()));
        end
        idle(2, 1'b1);

        // Single fetch of word 0
        step(1'b1, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        idle(4, 1'b1);

        // Back-to-back fetches
        step(1'b1, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b1, 32'd4, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b1, 32'd8, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        idle(5, 1'b1);

        // Stall: third request refused until the first consume
        step(1'b1, 32'd12, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b1, 32'd16, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b1, 32'd20, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        idle(3, 1'b0);
        idle(5, 1'b1);

        // Misaligned and out-of-range fetches
        step(1'b1, 32'd2, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b1, 32'd4096, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        idle(5, 1'b1);

        // Flush with two in flight, consume attempted in the flush cycle
        step(1'b1, 32'd24, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b1, 32'd28, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0);
        step(1'b1, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        idle(5, 1'b1);

        // Asynchronous reset with a buffered response
        step(1'b1, 32'd8, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        idle(3, 1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk("async_reset_valid", 32'(bus_if.io_resp_valid), 32'd0);
        idle(2, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(3, 1'b1);

        // Randomised traffic with stalls, flushes and loads
        rv = 1'b0;
        ra = 32'd0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            if (!rv || dut_acc) begin
                rv = ($urandom_range(0, 9) < 7);
                ra = rand_addr();
            end
            le = ($urandom_range(0, 99) < 4);
            la = ($urandom_range(0, 9) < 9) ? 32'($urandom_range(0, 63)) * 32'd4
                                            : 32'd4096 + 32'($urandom_range(0, 63));
            step(rv, ra, ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) < 3),
                 le, la, 32'($urandom()));
        end

        // Drain: every expected response must have appeared within the budget
        idle(20, 1'b1);
        @(negedge clk);
        #1 chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
